piano_mode_ctrl: RTL and testbench
==================================

Name: piano_mode_ctrl

Overview:
Parametrised control and output-arbitration core for the piano. It debounces the prev/pause/next buttons and decodes the mode switches. It tracks the selected song and the pause state for NUM_SONGS songs and muxes NUM_SRC player sources onto the single speaker and LED bank. A mute window suppresses clicks whenever the mode changes. Sits between the board inputs and the auto/keyboard/study players; replaces hard-wired 2-bit song selection and the unregistered output mux.

Parameters:
NUM_SONGS, 4, number of selectable songs (>=2)
SONG_W, $clog2(NUM_SONGS), width of song_num
NUM_SRC, 3, player sources; index 0 auto, 1 manual, 2 study
LED_W, 8, LED bank width
DEBOUNCE_CYC, 2000000, consecutive stable cycles required to accept a button level
MUTE_CYC, 100000, output-mute length after a mode change

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
button  in  3  raw buttons; 0 prev, 1 pause, 2 next (asynchronous)
mode  in  3  mode switches; 011 auto, 001 manual, 111 study, other idle
src_speaker  in  NUM_SRC  per-source speaker bit
src_led  in  NUM_SRC*LED_W  per-source LED bus, source i at [i*LED_W +: LED_W]
song_num  out  SONG_W  selected song
pause  out  1  pause flag to the auto/study players
active_src  out  NUM_SRC  one-hot active source; all-zero when idle
song_change  out  1  one-cycle pulse when song_num changes
speaker  out  1  muxed, registered speaker
led  out  LED_W  muxed, registered LEDs

Behaviour:
- Reset (rst=1 at a clk edge): song_num=0, pause=0, active_src=0, song_change=0, speaker=0, led=0. Debouncers clear to level 0, count 0. Mute counter=0. Stored mode=idle. Reset mid-press: the press is discarded and must be re-debounced.
- Debounce, per button:
  - 2-flop synchroniser, then a counter.
  - Counter increments while the synced value differs from the debounced level and clears when they are equal.
  - When the count reaches DEBOUNCE_CYC, the debounced level takes the synced value and the counter clears.
  - press pulse = 1 in the cycle the level goes 0->1. No pulse on release.
  - Latency from raw rise (settled before an edge) to pulse: 2+DEBOUNCE_CYC cycles.
- Mode decode is combinational into a registered mode_r: AUTO, MANUAL, STUDY, IDLE.
  - active_src is registered from mode_r.
  - When the decoded mode differs from mode_r: mode_r updates, pause clears to 0, and the mute counter loads MUTE_CYC.
  - Changing mode does not alter song_num.
- Song/pause FSM (states IDLE, RUN, PAUSED). Button pulses only act when mode_r is AUTO or STUDY; they are ignored in MANUAL and IDLE.
  - next: song_num = (song_num==NUM_SONGS-1) ? 0 : song_num+1.
  - prev: song_num = (song_num==0) ? NUM_SONGS-1 : song_num-1.
  - prev and next in the same cycle: both ignored.
  - Any song change forces pause=0 (RUN) and asserts song_change for exactly 1 cycle, the cycle after song_num updates.
  - pause pulse toggles pause between RUN and PAUSED.
  - pause together with next or prev in the same cycle: the song change wins and pause=0.
  - Pulse timing: a pulse in cycle t updates song_num or pause at edge t+1.
- Output mux (registered, 1-cycle latency from src_* inputs):
  - If mute counter != 0 or mode_r == IDLE: speaker=0, led=0.
  - Otherwise speaker and led come from the active source.
  - Mute counter decrements to 0 each cycle and never wraps.
  - A further mode change during the mute window reloads MUTE_CYC.

Decomposition:
- Shared package piano_pkg holds:
  - mode encodings (MODE_AUTO=3'b011, MODE_MANUAL=3'b001, MODE_STUDY=3'b111)
  - source indices (SRC_AUTO=0, SRC_MANUAL=1, SRC_STUDY=2)
  - button indices (BTN_PREV=0, BTN_PAUSE=1, BTN_NEXT=2)
  - FSM state typedef
- One sub-module, btn_debounce: synchroniser, counter and press pulse, parameterised by DEBOUNCE_CYC, instantiated 3 times.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, MUTE_CYC=8, NUM_SONGS=4.
1. Reset, then mode=011, hold button[2] high 20 cycles -> one song_change pulse; song_num 0->1 exactly 7 cycles after the raw rise (2 sync + 4 debounce + 1 update); no further change while held.
2. In AUTO, press next four times, then prev once from song 0 -> song_num 1,2,3,0, then 3 (both wraps).
3. Press pause -> pause=1; press next -> song_num increments and pause=0 in the same cycle. Press pause and next together -> song change, pause=0. Press prev and next together -> no change, no song_change pulse.
4. Bounce button[0] 1-0-1-0 every 2 cycles, then hold low -> no pulse, song_num unchanged. Repeat with mode=001 and a clean press -> ignored.
5. Switch mode 011->111 with src_speaker=3'b111 and src_led[23:16]=8'hA5 -> speaker=0, led=0 for 8 cycles, then led=8'hA5. Pause cleared; song_num preserved. Mode=000 -> outputs 0 and active_src=0.
6. Assert rst for 1 cycle mid-debounce at song_num=2 with pause=1 -> all outputs 0 next cycle; the pending press produces no pulse.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared encodings for the piano control core: switch/button/source
// indices, the decoded mode type and the song/pause state type.
package piano_pkg;

  // Raw mode-switch encodings; any other pattern means idle.
  localparam logic [2:0] MODE_AUTO   = 3'b011;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_STUDY  = 3'b111;

  // Player source indices into src_speaker / src_led.
  localparam int SRC_AUTO   = 0;
  localparam int SRC_MANUAL = 1;
  localparam int SRC_STUDY  = 2;

  // Button bit positions.
  localparam int BTN_PREV  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;

  // Decoded, registered operating mode.
  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_AUTO   = 2'd1,
    MD_MANUAL = 2'd2,
    MD_STUDY  = 2'd3
  } mode_t;

  // Song/pause FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } play_state_t;

  // Map the raw switch pattern onto a decoded mode.
  function automatic mode_t decode_mode(input logic [2:0] sw);
    mode_t m;
    case (sw)
      MODE_AUTO:   m = MD_AUTO;
      MODE_MANUAL: m = MD_MANUAL;
      MODE_STUDY:  m = MD_STUDY;
      default:     m = MD_IDLE;
    endcase
    return m;
  endfunction

  // Song navigation and pause only apply to the song-playing modes.
  function automatic logic buttons_enabled(input mode_t m);
    return (m == MD_AUTO) || (m == MD_STUDY);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise the raw input, then accept a new level only after it has
  // differed from the current level for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/piano_mode_ctrl.sv
// Piano control core: debounced prev/pause/next buttons, mode decode with
// a post-change mute window, song/pause FSM and a registered output mux
// that routes one player source to the speaker and LED bank.
module piano_mode_ctrl
  import piano_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = $clog2(NUM_SONGS),
  parameter int NUM_SRC      = 3,
  parameter int LED_W        = 8,
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int MUTE_CYC     = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               button,
  input  logic [2:0]               mode,
  input  logic [NUM_SRC-1:0]       src_speaker,
  input  logic [NUM_SRC*LED_W-1:0] src_led,
  output logic [SONG_W-1:0]        song_num,
  output logic                     pause,
  output logic [NUM_SRC-1:0]       active_src,
  output logic                     song_change,
  output logic                     speaker,
  output logic [LED_W-1:0]         led
);

  localparam int MUTE_W = $clog2(MUTE_CYC + 1);
  localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYC);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

  logic [2:0]        press;
  mode_t             mode_dec;
  mode_t             mode_r;
  logic              mode_chg;
  logic [MUTE_W-1:0] mute_cnt;
  play_state_t       state;
  logic              btn_en;
  logic              do_next;
  logic              do_prev;
  logic              do_pause;

  // One debouncer per button.
  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (button[i]),
      .press(press[i])
    );
  end

  assign mode_dec = decode_mode(mode);
  assign mode_chg = (mode_dec != mode_r);

  // prev and next together cancel each other.
  assign btn_en   = buttons_enabled(mode_r);
  assign do_next  = btn_en && press[BTN_NEXT] && !press[BTN_PREV];
  assign do_prev  = btn_en && press[BTN_PREV] && !press[BTN_NEXT];
  assign do_pause = btn_en && press[BTN_PAUSE];

  function automatic logic [NUM_SRC-1:0] src_onehot(input mode_t m);
    logic [NUM_SRC-1:0] v;
    v = '0;
    case (m)
      MD_AUTO:   v[SRC_AUTO]   = 1'b1;
      MD_MANUAL: v[SRC_MANUAL] = 1'b1;
      MD_STUDY:  v[SRC_STUDY]  = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Track the decoded mode, (re)arm the mute window on every change and
  // publish the active source one-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= MD_IDLE;
      mute_cnt   <= '0;
      active_src <= '0;
    end else begin
      if (mode_chg) begin
        mode_r   <= mode_dec;
        mute_cnt <= MUTE_LOAD;
      end else if (mute_cnt != '0) begin
        mute_cnt <= mute_cnt - MUTE_W'(1);
      end
      active_src <= src_onehot(mode_r);
    end
  end

  // Song/pause FSM: a song change wins over pause and always resumes play;
  // a mode change clears pause last so it overrides any toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      song_num    <= '0;
      pause       <= 1'b0;
      song_change <= 1'b0;
    end else begin
      song_change <= 1'b0;
      if (do_next || do_prev) begin
        if (do_next) begin
          song_num <= (song_num == SONG_LAST) ? '0 : song_num + SONG_W'(1);
        end else begin
          song_num <= (song_num == '0) ? SONG_LAST : song_num - SONG_W'(1);
        end
        song_change <= 1'b1;
        state       <= ST_RUN;
        pause       <= 1'b0;
      end else if (do_pause) begin
        if (state == ST_PAUSED) begin
          state <= ST_RUN;
          pause <= 1'b0;
        end else begin
          state <= ST_PAUSED;
          pause <= 1'b1;
        end
      end
      if (mode_chg) begin
        state <= buttons_enabled(mode_dec) ? ST_RUN : ST_IDLE;
        pause <= 1'b0;
      end
    end
  end

  // Registered output mux, forced silent while muted or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      speaker <= 1'b0;
      led     <= '0;
    end else if ((mute_cnt != '0) || (mode_r == MD_IDLE)) begin
      speaker <= 1'b0;
      led     <= '0;
    end else begin
      case (mode_r)
        MD_AUTO: begin
          speaker <= src_speaker[SRC_AUTO];
          led     <= src_led[SRC_AUTO*LED_W +: LED_W];
        end
        MD_MANUAL: begin
          speaker <= src_speaker[SRC_MANUAL];
          led     <= src_led[SRC_MANUAL*LED_W +: LED_W];
        end
        MD_STUDY: begin
          speaker <= src_speaker[SRC_STUDY];
          led     <= src_led[SRC_STUDY*LED_W +: LED_W];
        end
        default: begin
          speaker <= 1'b0;
          led     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piano_mode_ctrl.sv
// Directed bench for piano_mode_ctrl with short debounce/mute settings.
module tb_piano_mode_ctrl;

  localparam int NUM_SONGS = 4;
  localparam int SONG_W    = 2;
  localparam int NUM_SRC   = 3;
  localparam int LED_W     = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [2:0]               button;
  logic [2:0]               mode;
  logic [NUM_SRC-1:0]       src_speaker;
  logic [NUM_SRC*LED_W-1:0] src_led;
  logic [SONG_W-1:0]        song_num;
  logic                     pause;
  logic [NUM_SRC-1:0]       active_src;
  logic                     song_change;
  logic                     speaker;
  logic [LED_W-1:0]         led;

  int n_vec = 0;
  int n_err = 0;
  int chg_cnt = 0;
  int c0;

  typedef struct {
    logic [2:0] btn;
    logic [2:0] mode;
    logic [1:0] exp_song;
    logic       exp_pause;
    int         exp_chg;
  } vec_t;

  vec_t vecs[18];

  piano_mode_ctrl #(
    .NUM_SONGS   (NUM_SONGS),
    .SONG_W      (SONG_W),
    .NUM_SRC     (NUM_SRC),
    .LED_W       (LED_W),
    .DEBOUNCE_CYC(4),
    .MUTE_CYC    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .mode       (mode),
    .src_speaker(src_speaker),
    .src_led    (src_led),
    .song_num   (song_num),
    .pause      (pause),
    .active_src (active_src),
    .song_change(song_change),
    .speaker    (speaker),
    .led        (led)
  );

  // Clock
  always #5 clk = ~clk;

  // Count cycles with song_change high, sampled away from the active edge.
  always @(negedge clk) begin
    if (song_change) chg_cnt++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold buttons long enough to debounce, then release and let it settle.
  task automatic press_btn(input logic [2:0] b);
    @(negedge clk) button = b;
    repeat (10) @(negedge clk);
    button = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    //            btn     mode    song   pause chg
    vecs[0]  = '{3'b100, 3'b011, 2'd2, 1'b0, 1};
    vecs[1]  = '{3'b100, 3'b011, 2'd3, 1'b0, 1};
    vecs[2]  = '{3'b100, 3'b011, 2'd0, 1'b0, 1};
    vecs[3]  = '{3'b001, 3'b011, 2'd3, 1'b0, 1};
    vecs[4]  = '{3'b100, 3'b011, 2'd0, 1'b0, 1};
    vecs[5]  = '{3'b010, 3'b011, 2'd0, 1'b1, 0};
    vecs[6]  = '{3'b100, 3'b011, 2'd1, 1'b0, 1};
    vecs[7]  = '{3'b010, 3'b011, 2'd1, 1'b1, 0};
    vecs[8]  = '{3'b110, 3'b011, 2'd2, 1'b0, 1};
    vecs[9]  = '{3'b101, 3'b011, 2'd2, 1'b0, 0};
    vecs[10] = '{3'b010, 3'b011, 2'd2, 1'b1, 0};
    vecs[11] = '{3'b010, 3'b011, 2'd2, 1'b0, 0};
    vecs[12] = '{3'b100, 3'b001, 2'd2, 1'b0, 0};
    vecs[13] = '{3'b010, 3'b011, 2'd2, 1'b1, 0};
    vecs[14] = '{3'b000, 3'b111, 2'd2, 1'b0, 0};
    vecs[15] = '{3'b100, 3'b111, 2'd3, 1'b0, 1};
    vecs[16] = '{3'b100, 3'b000, 2'd3, 1'b0, 0};
    vecs[17] = '{3'b001, 3'b011, 2'd2, 1'b0, 1};

    // Reset
    rst = 1'b1;
    button = 3'b000;
    mode = 3'b000;
    src_speaker = '0;
    src_led = '0;
    repeat (3) @(negedge clk);
    check("rst_song", 32'(song_num), 32'd0);
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_active", 32'(active_src), 32'd0);
    check("rst_chg", 32'(song_change), 32'd0);
    check("rst_spk", 32'(speaker), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;

    // Scenario 1: latency of a held next press
    mode = 3'b011;
    repeat (3) @(negedge clk);
    check("auto_active", 32'(active_src), 32'b001);
    c0 = chg_cnt;
    button = 3'b100;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) check("lat_before", 32'(song_num), 32'd0);
      if (i == 7) begin
        check("lat_at", 32'(song_num), 32'd1);
        check("lat_chg", 32'(song_change), 32'd1);
      end
    end
    check("held_song", 32'(song_num), 32'd1);
    @(negedge clk) button = 3'b000;
    repeat (10) @(negedge clk);
    check("held_chg_cnt", 32'(chg_cnt - c0), 32'd1);

    // Table of single presses across modes
    for (int v = 0; v < 18; v++) begin
      if (mode != vecs[v].mode) begin
        mode = vecs[v].mode;
        repeat (3) @(negedge clk);
      end
      c0 = chg_cnt;
      if (vecs[v].btn != 3'b000) press_btn(vecs[v].btn);
      else repeat (3) @(negedge clk);
      check($sformatf("v%0d_song", v), 32'(song_num), 32'(vecs[v].exp_song));
      check($sformatf("v%0d_pause", v), 32'(pause), 32'(vecs[v].exp_pause));
      check($sformatf("v%0d_chg", v), 32'(chg_cnt - c0), 32'(vecs[v].exp_chg));
    end

    // Scenario 4: bouncing prev never settles
    c0 = chg_cnt;
    @(negedge clk) button = 3'b001;
    repeat (2) @(negedge clk);
    button = 3'b000;
    repeat (2) @(negedge clk);
    button = 3'b001;
    repeat (2) @(negedge clk);
    button = 3'b000;
    repeat (12) @(negedge clk);
    check("bounce_song", 32'(song_num), 32'd2);
    check("bounce_chg", 32'(chg_cnt - c0), 32'd0);

    // Scenario 5: mute window on auto -> study
    src_speaker = 3'b111;
    src_led = {8'hA5, 8'h3C, 8'h5A};
    press_btn(3'b010);
    check("pre_mute_pause", 32'(pause), 32'd1);
    check("pre_mute_led", 32'(led), 32'h5A);
    check("pre_mute_spk", 32'(speaker), 32'd1);
    @(negedge clk) mode = 3'b111;
    @(posedge clk);
    #1;
    check("chg_pause", 32'(pause), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mute%0d_led", i), 32'(led), 32'd0);
      check($sformatf("mute%0d_spk", i), 32'(speaker), 32'd0);
    end
    @(posedge clk);
    #1;
    check("unmute_led", 32'(led), 32'hA5);
    check("unmute_spk", 32'(speaker), 32'd1);
    check("study_active", 32'(active_src), 32'b100);
    check("study_song", 32'(song_num), 32'd2);
    @(negedge clk) mode = 3'b000;
    repeat (3) @(negedge clk);
    check("idle_led", 32'(led), 32'd0);
    check("idle_spk", 32'(speaker), 32'd0);
    check("idle_active", 32'(active_src), 32'd0);

    // Scenario 6: reset mid-debounce
    mode = 3'b011;
    repeat (3) @(negedge clk);
    press_btn(3'b010);
    check("r6_pause", 32'(pause), 32'd1);
    check("r6_song", 32'(song_num), 32'd2);
    button = 3'b100;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    button = 3'b000;
    @(negedge clk) rst = 1'b0;
    check("r6_rst_song", 32'(song_num), 32'd0);
    check("r6_rst_pause", 32'(pause), 32'd0);
    check("r6_rst_active", 32'(active_src), 32'd0);
    check("r6_rst_led", 32'(led), 32'd0);
    check("r6_rst_spk", 32'(speaker), 32'd0);
    c0 = chg_cnt;
    repeat (15) @(negedge clk);
    check("r6_post_song", 32'(song_num), 32'd0);
    check("r6_post_chg", 32'(chg_cnt - c0), 32'd0);
    check("r6_post_active", 32'(active_src), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
